// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions: address/state widths and the phase encoding
// consumed by the sequencer and the datapath muxes.
package pc_sequencer_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned ST_W   = 3;

    typedef enum logic [ST_W-1:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        WAIT_IN = 3'd5,
        HALT    = 3'd6
    } state_t;

endpackage

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC selection: JR beats J/JAL beats a resolved branch,
// otherwise PC+1 wrapping modulo 2^addr.
module pc_next_sel
    import pc_sequencer_pkg::*;
#(
    parameter int addr = ADDR_W
) (
    input  logic [addr-1:0] pc,
    input  logic            rr,
    input  logic            jump,
    input  logic            jal,
    input  logic            branch,
    input  logic [addr-1:0] rt_addr,
    input  logic [addr-1:0] target_addr,
    output logic [addr-1:0] next_pc
);

    always_comb begin
        next_pc = pc + addr'(1);
        if (rr) begin
            next_pc = rt_addr;
        end else if (jump || jal) begin
            next_pc = target_addr;
        end else if (branch) begin
            next_pc = target_addr;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Five-phase instruction sequencer: owns the PC, the JAL return address and
// the control flags captured at EXEC for the instruction in flight.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int addr = ADDR_W,
    parameter int st   = ST_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flagJump,
    input  logic            flagJAL,
    input  logic            flagRR,
    input  logic            flagBRANCH,
    input  logic            flagIN,
    input  logic            flagHALT,
    input  logic            inReady,
    input  logic [addr-1:0] targetAddress,
    input  logic [addr-1:0] rtAddress,
    output logic [addr-1:0] PC,
    output logic [st-1:0]   State,
    output logic [addr-1:0] addressJAL,
    output logic            halted
);

    state_t          state, state_nx;
    logic [addr-1:0] pc, pc_inc, pc_next, address_jal;
    logic [addr-1:0] lat_target, lat_rt;
    logic            lat_jump, lat_jal, lat_rr;

    assign pc_inc = pc + addr'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = FETCH;
        case (state)
            FETCH:   state_nx = DECODE;
            DECODE:  state_nx = EXEC;
            EXEC: begin
                if (flagHALT) begin
                    state_nx = HALT;
                end else if (flagIN) begin
                    state_nx = WAIT_IN;
                end else begin
                    state_nx = MEM;
                end
            end
            MEM:     state_nx = WB;
            WB:      state_nx = FETCH;
            WAIT_IN: state_nx = inReady ? WB : WAIT_IN;
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // Branch is live (resolved at write-back); everything else uses the EXEC snapshot.
    pc_next_sel #(
        .addr(addr)
    ) u_next_sel (
        .pc         (pc),
        .rr         (lat_rr),
        .jump       (lat_jump),
        .jal        (lat_jal),
        .branch     (flagBRANCH),
        .rt_addr    (lat_rt),
        .target_addr(lat_target),
        .next_pc    (pc_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            address_jal <= '0;
            lat_target  <= '0;
            lat_rt      <= '0;
            lat_jump    <= 1'b0;
            lat_jal     <= 1'b0;
            lat_rr      <= 1'b0;
        end else begin
            if (state == EXEC) begin
                lat_jump   <= flagJump;
                lat_jal    <= flagJAL;
                lat_rr     <= flagRR;
                lat_target <= targetAddress;
                lat_rt     <= rtAddress;
                if (flagJAL) begin
                    address_jal <= pc_inc;
                end
            end
            if (state == WB) begin
                pc <= pc_next;
            end
        end
    end

    assign PC         = pc;
    assign State      = st'(state);
    assign addressJAL = address_jal;
    assign halted     = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: PC/addressJAL expectations are queued
// when an instruction's controls are driven and compared when they appear.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        flagJump, flagJAL, flagRR, flagBRANCH, flagIN, flagHALT, inReady;
    logic [19:0] targetAddress, rtAddress;
    logic [19:0] PC, addressJAL;
    logic [2:0]  State;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [19:0] pc_q[$];
    logic [19:0] jal_q[$];

    pc_sequencer #(
        .addr(20),
        .st  (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flagJump     (flagJump),
        .flagJAL      (flagJAL),
        .flagRR       (flagRR),
        .flagBRANCH   (flagBRANCH),
        .flagIN       (flagIN),
        .flagHALT     (flagHALT),
        .inReady      (inReady),
        .targetAddress(targetAddress),
        .rtAddress    (rtAddress),
        .PC           (PC),
        .State        (State),
        .addressJAL   (addressJAL),
        .halted       (halted)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pop_pc(input string tag);
        if (pc_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else check(tag, {12'd0, PC}, {12'd0, pc_q.pop_front()});
    endtask

    task automatic pop_jal(input string tag);
        if (jal_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else check(tag, {12'd0, addressJAL}, {12'd0, jal_q.pop_front()});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, {12'd0, PC}, 32'd0);
        check({tag, "_state"}, {29'd0, State}, 32'd0);
        check({tag, "_jal"}, {12'd0, addressJAL}, 32'd0);
        check({tag, "_halted"}, {31'd0, halted}, 32'd0);
    endtask

    // One full instruction from FETCH back to FETCH; entry/exit at edge+1 in FETCH.
    task automatic instr(input string tag, input logic j, input logic jal, input logic rr,
                         input logic br_mem, input logic br_wb,
                         input logic [19:0] tgt, input logic [19:0] rt,
                         input logic [19:0] exp_pc, input logic [19:0] exp_jal);
        check({tag, "_fetch"}, {29'd0, State}, 32'd0);
        tick();
        tick();
        check({tag, "_exec"}, {29'd0, State}, 32'd2);
        flagJump = j; flagJAL = jal; flagRR = rr;
        targetAddress = tgt; rtAddress = rt;
        pc_q.push_back(exp_pc);
        jal_q.push_back(exp_jal);
        tick();
        flagJump = 1'b0; flagJAL = 1'b0; flagRR = 1'b0;
        targetAddress = 20'h5A5A5; rtAddress = 20'hA5A5A;
        flagBRANCH = br_mem;
        pop_jal({tag, "_jal"});
        tick();
        flagBRANCH = br_wb;
        check({tag, "_wb"}, {29'd0, State}, 32'd4);
        tick();
        flagBRANCH = 1'b0;
        check({tag, "_refetch"}, {29'd0, State}, 32'd0);
        pop_pc({tag, "_pc"});
    endtask

    initial begin
        reset = 1'b1;
        {flagJump, flagJAL, flagRR, flagBRANCH, flagIN, flagHALT, inReady} = '0;
        targetAddress = '0;
        rtAddress = '0;
        #12;
        check_reset_vals("por");
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pc_q.push_back((i < 5) ? 20'h0 : 20'h1);
            check($sformatf("seq_state%0d", i), {29'd0, State}, i % 5);
            pop_pc($sformatf("seq_pc%0d", i));
            tick();
        end

        instr("j10",    1, 0, 0, 0, 0, 20'h00010, 20'h0,     20'h00010, 20'h00000);
        instr("jal",    1, 1, 0, 0, 0, 20'h00200, 20'h0,     20'h00200, 20'h00011);
        instr("jr",     1, 0, 1, 0, 0, 20'h00300, 20'h0ABCD, 20'h0ABCD, 20'h00011);
        instr("jmax",   1, 0, 0, 0, 0, 20'hFFFFF, 20'h0,     20'hFFFFF, 20'h00011);
        instr("wrap",   0, 0, 0, 0, 0, 20'h00000, 20'h0,     20'h00000, 20'h00011);
        instr("jmax2",  1, 0, 0, 0, 0, 20'hFFFFF, 20'h0,     20'hFFFFF, 20'h00011);
        instr("jalwrp", 0, 1, 0, 0, 0, 20'h00777, 20'h0,     20'h00777, 20'h00000);
        instr("brmem",  0, 0, 0, 1, 0, 20'h00040, 20'h0,     20'h00778, 20'h00000);
        instr("brwb",   0, 0, 0, 0, 1, 20'h00040, 20'h0,     20'h00040, 20'h00000);
        instr("jal41",  0, 1, 0, 0, 0, 20'h00100, 20'h0,     20'h00100, 20'h00041);

        // WAIT_IN: inReady coinciding with EXEC must not shortcut the wait.
        tick();
        tick();
        check("win_exec", {29'd0, State}, 32'd2);
        flagIN = 1'b1;
        inReady = 1'b1;
        pc_q.push_back(20'h00101);
        tick();
        flagIN = 1'b0;
        inReady = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            check($sformatf("win_state%0d", i), {29'd0, State}, 32'd5);
            check($sformatf("win_pc%0d", i), {12'd0, PC}, 32'h100);
        end
        inReady = 1'b1;
        tick();
        inReady = 1'b0;
        check("win_wb", {29'd0, State}, 32'd4);
        tick();
        check("win_fetch", {29'd0, State}, 32'd0);
        pop_pc("win_pc_next");

        // HALT wins over flagIN and is absorbing.
        tick();
        tick();
        flagHALT = 1'b1;
        flagIN = 1'b1;
        tick();
        flagHALT = 1'b0;
        flagIN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            inReady = (i == 2);
            check($sformatf("halt_state%0d", i), {29'd0, State}, 32'd6);
            check($sformatf("halt_flag%0d", i), {31'd0, halted}, 32'd1);
            check($sformatf("halt_pc%0d", i), {12'd0, PC}, 32'h101);
            tick();
        end
        inReady = 1'b0;

        #3 reset = 1'b1;
        #1 check_reset_vals("rst_halt");
        @(posedge clock);
        #1 reset = 1'b0;
        check("rst_halt_pc0", {12'd0, PC}, 32'd0);

        instr("jal20",  0, 1, 0, 0, 0, 20'h00020, 20'h0,     20'h00020, 20'h00001);

        tick();
        tick();
        flagIN = 1'b1;
        tick();
        flagIN = 1'b0;
        tick();
        check("rwin_state", {29'd0, State}, 32'd5);
        #3 reset = 1'b1;
        #1 check_reset_vals("rst_win");
        @(posedge clock);
        #1 reset = 1'b0;
        check("rst_win_pc0", {12'd0, PC}, 32'd0);
        instr("restart", 0, 0, 0, 0, 0, 20'h00000, 20'h0,    20'h00001, 20'h00000);

        check("sb_drain_pc", pc_q.size(), 32'd0);
        check("sb_drain_jal", jal_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
